// File: rtl/aud_pkg.sv
// Shared types and constants for the audio codec serial paths.
package aud_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ALIGN,
    S_SHIFT,
    S_PAD
  } aud_ser_state_t;

  localparam logic CH_L = 1'b0;
  localparam logic CH_R = 1'b1;

endpackage

// File: rtl/aud_lrck_edge.sv
// DACLRCK/ADCLRCK edge detector: registers the frame clock on the BCLK
// falling edge and decodes which channel slot a detected edge opens.
module aud_lrck_edge #(
  parameter bit LEFT_LVL = 1'b0
) (
  input  logic bclk,
  input  logic rst_n,
  input  logic lrck,
  output logic left_start,
  output logic right_start
);

  logic lrck_q;
  logic lrck_chg;

  // Previous frame-clock level, sampled on every falling BCLK edge.
  always_ff @(negedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      lrck_q <= 1'b0;
    end else begin
      lrck_q <= lrck;
    end
  end

  // Slot-start decode from the current level versus the registered one.
  always_comb begin
    lrck_chg    = (lrck != lrck_q);
    left_start  = lrck_chg & (lrck == LEFT_LVL);
    right_start = lrck_chg & (lrck != LEFT_LVL);
  end

endmodule

// File: rtl/aud_dac_serializer.sv
// Stereo DAC serializer: one-entry L/R pair buffer, MSB-first shift onto
// DACDAT in I2S or left-justified framing against codec-mastered clocks.
module aud_dac_serializer
  import aud_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter bit          MODE_I2S = 1'b1,
  parameter bit          LEFT_LVL = 1'b0
) (
  input  logic              i_bclk,
  input  logic              i_rst_n,
  input  logic              i_daclrck,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_l_data,
  input  logic [DATA_W-1:0] i_r_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_aud_dacdat,
  output logic              o_underrun,
  output logic              o_frame_err
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  aud_ser_state_t    state, state_nx;
  logic [DATA_W-1:0] sh, sh_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              chan, chan_nx;
  logic [DATA_W-1:0] r_hold, r_hold_nx;
  logic [DATA_W-1:0] l_buf, l_buf_nx;
  logic [DATA_W-1:0] r_buf, r_buf_nx;
  logic              buf_full, buf_full_nx;
  logic              dacdat_nx, underrun_nx, frame_err_nx;
  logic              left_start, right_start;
  logic              take_left, take_right;
  logic              load, consume;
  logic [DATA_W-1:0] word;

  aud_lrck_edge #(
    .LEFT_LVL (LEFT_LVL)
  ) u_lrck_edge (
    .bclk        (i_bclk),
    .rst_n       (i_rst_n),
    .lrck        (i_daclrck),
    .left_start  (left_start),
    .right_start (right_start)
  );

  // Ready is held low during reset so nothing can be accepted mid-clear.
  assign o_ready = i_en & ~buf_full & i_rst_n;

  // State, datapath and output registers, all on the falling BCLK edge.
  always_ff @(negedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= S_IDLE;
      sh           <= '0;
      cnt          <= '0;
      chan         <= CH_L;
      r_hold       <= '0;
      l_buf        <= '0;
      r_buf        <= '0;
      buf_full     <= 1'b0;
      o_aud_dacdat <= 1'b0;
      o_underrun   <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      state        <= state_nx;
      sh           <= sh_nx;
      cnt          <= cnt_nx;
      chan         <= chan_nx;
      r_hold       <= r_hold_nx;
      l_buf        <= l_buf_nx;
      r_buf        <= r_buf_nx;
      buf_full     <= buf_full_nx;
      o_aud_dacdat <= dacdat_nx;
      o_underrun   <= underrun_nx;
      o_frame_err  <= frame_err_nx;
    end
  end

  // Next-state, slot start, bit emission and buffer handshake.
  always_comb begin
    state_nx     = state;
    sh_nx        = sh;
    cnt_nx       = cnt;
    chan_nx      = chan;
    r_hold_nx    = r_hold;
    l_buf_nx     = l_buf;
    r_buf_nx     = r_buf;
    buf_full_nx  = buf_full;
    dacdat_nx    = 1'b0;
    underrun_nx  = 1'b0;
    frame_err_nx = 1'b0;
    load         = 1'b0;
    consume      = 1'b0;
    word         = '0;
    take_left    = left_start & (state != S_IDLE);
    take_right   = right_start & ((state == S_SHIFT) || (state == S_PAD));

    if (!i_en) begin
      state_nx    = S_IDLE;
      buf_full_nx = 1'b0;
    end else begin
      if (state == S_IDLE) begin
        state_nx = S_ALIGN;
      end else if (take_left) begin
        load         = 1'b1;
        chan_nx      = CH_L;
        frame_err_nx = (state == S_SHIFT);
        if (buf_full) begin
          word      = l_buf;
          r_hold_nx = r_buf;
          consume   = 1'b1;
        end else begin
          r_hold_nx   = '0;
          underrun_nx = 1'b1;
        end
      end else if (take_right) begin
        load         = 1'b1;
        chan_nx      = CH_R;
        word         = r_hold;
        frame_err_nx = (state == S_SHIFT);
      end else if (state == S_SHIFT) begin
        dacdat_nx = sh[DATA_W-1];
        sh_nx     = {sh[DATA_W-2:0], 1'b0};
        cnt_nx    = cnt + CNT_W'(1);
        if (cnt == CNT_W'(DATA_W - 1)) begin
          state_nx = S_PAD;
        end
      end

      // cnt counts bits already driven, so left-justified starts at 1
      // because its MSB leaves on the slot-start edge itself.
      if (load) begin
        state_nx = S_SHIFT;
        if (MODE_I2S) begin
          sh_nx     = word;
          cnt_nx    = '0;
          dacdat_nx = 1'b0;
        end else begin
          sh_nx     = {word[DATA_W-2:0], 1'b0};
          cnt_nx    = CNT_W'(1);
          dacdat_nx = word[DATA_W-1];
        end
      end

      // Consume reads the old entry; a pair accepted on the same edge is
      // kept for the following frame.
      if (consume) begin
        buf_full_nx = 1'b0;
      end
      if (i_valid && !buf_full) begin
        l_buf_nx    = i_l_data;
        r_buf_nx    = i_r_data;
        buf_full_nx = 1'b1;
      end
    end
  end

endmodule
